// File: rtl/output_stream_if_if.sv
// ---------------------------------------------------------------------------
// output_stream_if_if
// AXI4-Stream bundle used by the egress transmitter.
//   master modport : drives TVALID/TDATA/TKEEP/TLAST/TUSER, samples TREADY
//   slave  modport : samples payload and valid, drives TREADY
// Parameters: TBITS data width, TBYTE keep width (TBITS/8).
// ---------------------------------------------------------------------------
interface output_stream_if_if #(
  parameter int TBITS = 64,
  parameter int TBYTE = 8
);
  logic             TVALID;
  logic             TREADY;
  logic [TBITS-1:0] TDATA;
  logic [TBYTE-1:0] TKEEP;
  logic             TLAST;
  logic             TUSER;

  modport master (
    output TVALID, TDATA, TKEEP, TLAST, TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TLAST, TUSER,
    output TREADY
  );
endinterface

// File: rtl/output_stream_if.sv
// ---------------------------------------------------------------------------
// output_stream_if
// AXI4-Stream master transmitter. Compute-side logic pushes words through a
// FIFO-style write port; the words are buffered in a DEPTH-entry FIFO
// followed by one output register and sent out on the AXIS master port.
// Total capacity is DEPTH+1 words.
//
// Ports:
//   ACLK, ARESETN        clock (rising edge) and async active-low reset
//   osif_data_din        write data            -> TDATA
//   osif_strb_din        write byte strobe     -> TKEEP
//   osif_last_din        end-of-packet marker  -> TLAST (default build)
//   osif_user_din        sideband              -> TUSER
//   osif_write           write request, taken only while osif_full_n=1
//   osif_full_n          1 = a write is accepted this cycle
//   osif_idle            1 = FIFO empty and nothing on the output
//   cfg_pkt_len          packet length in beats (auto-last build only)
//   m_axis               AXIS master modport
//
// Build option: define OSIF_AUTO_LAST_EN to generate TLAST from an internal
// beat counter (cfg_pkt_len beats per packet, 0 treated as 1) instead of
// forwarding osif_last_din.
// ---------------------------------------------------------------------------
module output_stream_if #(
  parameter int TBITS     = 64,
  parameter int TBYTE     = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [TBITS-1:0]     osif_data_din,
  input  logic [TBYTE-1:0]     osif_strb_din,
  input  logic                 osif_last_din,
  input  logic                 osif_user_din,
  input  logic                 osif_write,
  output logic                 osif_full_n,
  output logic                 osif_idle,
  input  logic [15:0]          cfg_pkt_len,
  output_stream_if_if.master   m_axis
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int EW    = TBITS + TBYTE + 2;
  localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [EW-1:0]      mem_q [DEPTH];
  logic [ADDR_BITS:0] wptr_q, wptr_d;
  logic [ADDR_BITS:0] rptr_q, rptr_d;
  logic               tvalid_q, tvalid_d;
  logic [TBITS-1:0]   tdata_q, tdata_d;
  logic [TBYTE-1:0]   tkeep_q, tkeep_d;
  logic               tlast_q, tlast_d;
  logic               tuser_q, tuser_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_en;
  logic               ld_en;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      head;

`ifdef OSIF_AUTO_LAST_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        pkt_end;
  // osif_last_din and the stored last bit are not used when TLAST is counted
  logic        unused_last;
  assign unused_last = osif_last_din ^ head[1];
`else
  logic        unused_cfg;
  assign unused_cfg = ^cfg_pkt_len;
`endif

  // Pointer-based occupancy: the extra MSB separates full from empty.
  // A write is judged against the registered full flag, so a word leaving
  // in the same cycle does not make room for a write at count=DEPTH.
  always_comb begin
    fifo_full  = (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]) &&
                 (wptr_q[ADDR_BITS-1:0] == rptr_q[ADDR_BITS-1:0]);
    fifo_empty = (wptr_q == rptr_q);
    wr_en      = osif_write && !fifo_full;
    ld_en      = !fifo_empty && (!tvalid_q || m_axis.TREADY);
    wr_entry   = {osif_data_din, osif_strb_din, osif_last_din, osif_user_din};
    head       = mem_q[rptr_q[ADDR_BITS-1:0]];
  end

  // Next-state for pointers and the output register. The output register
  // only changes when it is empty or its word is being taken, which keeps
  // TVALID and payload frozen while the sink stalls.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
`ifdef OSIF_AUTO_LAST_EN
    beat_cnt_d = beat_cnt_q;
    pkt_end    = (cfg_pkt_len == 16'd0) || (beat_cnt_q == cfg_pkt_len - 16'd1);
`endif

    if (wr_en) begin
      wptr_d = wptr_q + PTR_ONE;
    end

    if (ld_en) begin
      rptr_d   = rptr_q + PTR_ONE;
      tvalid_d = 1'b1;
      tdata_d  = head[EW-1 -: TBITS];
      tkeep_d  = head[TBYTE+1 -: TBYTE];
      tuser_d  = head[0];
`ifdef OSIF_AUTO_LAST_EN
      tlast_d    = pkt_end;
      beat_cnt_d = pkt_end ? 16'd0 : beat_cnt_q + 16'd1;
`else
      tlast_d  = head[1];
`endif
    end else if (tvalid_q && m_axis.TREADY) begin
      tvalid_d = 1'b0;
    end
  end

  // FIFO storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem_q[wptr_q[ADDR_BITS-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
`ifdef OSIF_AUTO_LAST_EN
      beat_cnt_q <= 16'd0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
`ifdef OSIF_AUTO_LAST_EN
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

  assign osif_full_n   = !fifo_full;
  assign osif_idle     = fifo_empty && !tvalid_q;
  assign m_axis.TVALID = tvalid_q;
  assign m_axis.TDATA  = tdata_q;
  assign m_axis.TKEEP  = tkeep_q;
  assign m_axis.TLAST  = tlast_q;
  assign m_axis.TUSER  = tuser_q;

endmodule

// File: tb/tb_output_stream_if.sv
// ---------------------------------------------------------------------------
// tb_output_stream_if
// Directed and randomised stimulus for output_stream_if. A behavioural
// occupancy model predicts osif_full_n, osif_idle and TVALID; accepted
// words go into an expected-beat queue that is compared against the AXIS
// output whenever TVALID is expected and popped on each handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_output_stream_if;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [63:0] osif_data_din = '0;
  logic [7:0]  osif_strb_din = '0;
  logic        osif_last_din = 1'b0;
  logic        osif_user_din = 1'b0;
  logic        osif_write = 1'b0;
  logic        osif_full_n;
  logic        osif_idle;
  logic [15:0] cfg_pkt_len = 16'd8;

  output_stream_if_if #(.TBITS(64), .TBYTE(8)) axis ();

  output_stream_if #(.TBITS(64), .TBYTE(8), .ADDR_BITS(4)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .osif_data_din (osif_data_din),
    .osif_strb_din (osif_strb_din),
    .osif_last_din (osif_last_din),
    .osif_user_din (osif_user_din),
    .osif_write    (osif_write),
    .osif_full_n   (osif_full_n),
    .osif_idle     (osif_idle),
    .cfg_pkt_len   (cfg_pkt_len),
    .m_axis        (axis)
  );

  always #5 ACLK = ~ACLK;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    m_cnt  = 0;
  bit    m_ov   = 1'b0;
  int    m_beat = 0;
  bit    m_acc  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_last(input logic l);
`ifdef OSIF_AUTO_LAST_EN
    int pl = int'(cfg_pkt_len);
    if (pl == 0 || m_beat == pl - 1) begin
      m_beat = 0;
      return 1'b1;
    end
    m_beat++;
    return 1'b0;
`else
    return l;
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check the
  // registered outputs against the model, then advance the model across
  // the coming rising edge.
  task automatic apply_stimulus(input bit w, input logic [63:0] d, input bit l, input bit tr);
    bit    full, ld;
    beat_t b;
    @(negedge ACLK);
    osif_write    = w;
    osif_data_din = d;
    osif_strb_din = d[7:0] ^ 8'h5A;
    osif_last_din = l;
    osif_user_din = d[0];
    axis.TREADY   = tr;
    #1;
    check("full_n", {63'd0, osif_full_n}, {63'd0, m_cnt != DEPTH});
    check("idle", {63'd0, osif_idle}, {63'd0, (m_cnt == 0) && !m_ov});
    check("tvalid", {63'd0, axis.TVALID}, {63'd0, m_ov});
    if (m_ov && exp_q.size() > 0) begin
      check("tdata", axis.TDATA, exp_q[0].data);
      check("tkeep", {56'd0, axis.TKEEP}, {56'd0, exp_q[0].keep});
      check("tlast", {63'd0, axis.TLAST}, {63'd0, exp_q[0].last});
      check("tuser", {63'd0, axis.TUSER}, {63'd0, exp_q[0].user});
    end
    full  = (m_cnt == DEPTH);
    m_acc = w && !full;
    ld    = (m_cnt > 0) && (!m_ov || tr);
    if (m_ov && tr && exp_q.size() > 0) void'(exp_q.pop_front());
    if (m_acc) begin
      b.data = d;
      b.keep = d[7:0] ^ 8'h5A;
      b.user = d[0];
      b.last = model_last(l);
      exp_q.push_back(b);
    end
    if (ld) m_ov = 1'b1;
    else if (m_ov && tr) m_ov = 1'b0;
    m_cnt = m_cnt + int'(m_acc) - int'(ld);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      apply_stimulus(1'b0, 64'd0, 1'b0, 1'b1);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_beat = 0;
  endtask

  // Asserts reset between edges and checks that outputs clear immediately.
  task automatic check_output_reset(input int cycles);
    @(negedge ACLK);
    osif_write = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    check("rst_tvalid", {63'd0, axis.TVALID}, 64'd0);
    check("rst_tdata", axis.TDATA, 64'd0);
    check("rst_tkeep", {56'd0, axis.TKEEP}, 64'd0);
    check("rst_tlast", {63'd0, axis.TLAST}, 64'd0);
    check("rst_full_n", {63'd0, osif_full_n}, 64'd1);
    check("rst_idle", {63'd0, osif_idle}, 64'd1);
    model_reset();
    repeat (cycles) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    int sent;
    int guard;
    axis.TREADY = 1'b0;

    // Power-on reset held for 3 cycles
    repeat (3) @(posedge ACLK);
    #1;
    check("por_tvalid", {63'd0, axis.TVALID}, 64'd0);
    check("por_tlast", {63'd0, axis.TLAST}, 64'd0);
    check("por_tdata", axis.TDATA, 64'd0);
    check("por_full_n", {63'd0, osif_full_n}, 64'd1);
    check("por_idle", {63'd0, osif_idle}, 64'd1);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Streaming 64 words with TREADY held high
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 64'(i), i == 63, 1'b1);
    drain(50);

    // Backpressure: 20 writes into a stalled sink, 3 get dropped
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 64'h1000 + 64'(i), i == 19, 1'b0);
    check("bp_full_n", {63'd0, osif_full_n}, 64'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0);
    drain(40);

    // Simultaneous write and load at FIFO count DEPTH-1 then DEPTH
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 64'h2000 + 64'(i), 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h2100, 1'b0, 1'b1);
    apply_stimulus(1'b1, 64'h2101, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'h2102, 1'b1, 1'b1);
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0);
    drain(40);

    // Random TREADY and write gaps, 300 accepted words
    sent  = 0;
    guard = 0;
    while (sent < 300 && guard < 5000) begin
      apply_stimulus($urandom_range(0, 2) != 0, {$urandom, $urandom},
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      if (m_acc) sent++;
      guard++;
    end
    check("random_timeout", 64'(sent), 64'd300);
    drain(200);

    // Reset mid-stream with 5 words in flight and the sink stalled
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 64'hA5A5_0000 + 64'(i + 1), 1'b0, 1'b0);
    check_output_reset(2);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 64'd0, 1'b0, 1'b1);

`ifdef OSIF_AUTO_LAST_EN
    // Counted TLAST: 8-beat packets, then every beat last
    check_output_reset(1);
    cfg_pkt_len = 16'd8;
    for (int i = 0; i < 32; i++) apply_stimulus(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b1);
    drain(40);
    cfg_pkt_len = 16'd0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 64'h4000 + 64'(i), 1'b0, 1'b1);
    drain(40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
